// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: operand/result handshake bundle for the nibble-serial adder.
//   in_valid/in_ready/a/b/cin : operand request from producer
//   out_valid/out_ready/sum/cout/ovf : result to consumer
//   busy : adder is in RUN or DONE
interface nibble_serial_add_ctrl_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf, busy);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf, busy);
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds two WIDTH-bit operands one nibble per cycle through a shared 4-bit CLA slice.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of nibble_serial_add_ctrl_if (operand in, result out, busy)
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input logic                     clk,
    input logic                     rst,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW+1:0]    sh;
    logic [3:0]       na, nb, p, g, s;
    logic             c1, c2, c3, c4;

    // Shared slice: carries are computed in parallel from the nibble's P/G terms.
    always_comb begin
        sh = {idx_q, 2'b00};
        na = 4'(a_q >> sh);
        nb = 4'(b_q >> sh);
        p  = na ^ nb;
        g  = na & nb;
        c1 = g[0] | (p[0] & carry_q);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & carry_q);
        s  = p ^ {c3, c2, c1, carry_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = RUN;
                a_d     = bus.a;
                b_d     = bus.b;
                carry_d = bus.cin;
                idx_d   = '0;
                sum_d   = '0;
            end
            RUN: begin
                sum_d   = (sum_q & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(s) << sh);
                carry_d = c4;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(NIB - 1)) begin
                    cout_d  = c4;
                    ovf_d   = c3 ^ c4;
                    state_d = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed and random checks of the nibble-serial adder at WIDTH 4, 16 and 32.
module tb_nibble_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_d = '0, b_d = '0;
    logic        cin_d = 1'b0, iv_d = 1'b0, ordy_d = 1'b0;
    int          sel = 1;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.WIDTH(4))  i4 ();
    nibble_serial_add_ctrl_if #(.WIDTH(16)) i16 ();
    nibble_serial_add_ctrl_if #(.WIDTH(32)) i32 ();

    nibble_serial_add_ctrl #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(i4));
    nibble_serial_add_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16));
    nibble_serial_add_ctrl #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(i32));

    assign i4.a  = a_d[3:0];
    assign i16.a = a_d[15:0];
    assign i32.a = a_d;
    assign i4.b  = b_d[3:0];
    assign i16.b = b_d[15:0];
    assign i32.b = b_d;
    assign i4.cin  = cin_d;
    assign i16.cin = cin_d;
    assign i32.cin = cin_d;
    assign i4.in_valid   = iv_d && sel == 0;
    assign i16.in_valid  = iv_d && sel == 1;
    assign i32.in_valid  = iv_d && sel == 2;
    assign i4.out_ready  = ordy_d && sel == 0;
    assign i16.out_ready = ordy_d && sel == 1;
    assign i32.out_ready = ordy_d && sel == 2;

    wire        ir_m   = sel == 0 ? i4.in_ready  : sel == 1 ? i16.in_ready  : i32.in_ready;
    wire        vld_m  = sel == 0 ? i4.out_valid : sel == 1 ? i16.out_valid : i32.out_valid;
    wire        busy_m = sel == 0 ? i4.busy      : sel == 1 ? i16.busy      : i32.busy;
    wire        co_m   = sel == 0 ? i4.cout      : sel == 1 ? i16.cout      : i32.cout;
    wire        ovf_m  = sel == 0 ? i4.ovf       : sel == 1 ? i16.ovf       : i32.ovf;
    wire [31:0] sum_m  = sel == 0 ? 32'(i4.sum)  : sel == 1 ? 32'(i16.sum)  : i32.sum;

    task automatic do_add(input logic [31:0] a, input logic [31:0] b, input logic c,
                          output logic [31:0] s, output logic co, output logic ov,
                          output int lat, output bit rdy_bad);
        a_d = a; b_d = b; cin_d = c; iv_d = 1'b1;
        @(posedge clk); #1;
        iv_d = 1'b0;
        lat = 0;
        rdy_bad = 0;
        while (!vld_m && lat < 64) begin
            if (ir_m || !busy_m) rdy_bad = 1;
            @(posedge clk); #1;
            lat++;
        end
        if (!vld_m) lat = -1;
        if (ir_m || !busy_m) rdy_bad = 1;
        s = sum_m; co = co_m; ov = ovf_m;
    endtask

    task automatic pop();
        ordy_d = 1'b1;
        @(posedge clk); #1;
        ordy_d = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ir_m, vld_m, busy_m} !== 3'b100) begin
            bad++; $display("FAIL reset_flags got %b want 100", {ir_m, vld_m, busy_m});
        end
        total++;
        if ({sum_m, co_m, ovf_m} !== 34'd0) begin
            bad++; $display("FAIL reset_regs got sum=%h cout=%b ovf=%b want 0", sum_m, co_m, ovf_m);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] s; logic co, ov; int lat; bit rb;
        sel = 1;
        do_add(32'hFFFF, 32'h0001, 1'b0, s, co, ov, lat, rb);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL basic_latency got %0d want 4", lat); end
        total++;
        if ({s, co, ov} !== {32'h0000, 1'b1, 1'b0}) begin
            bad++; $display("FAIL basic_result got %h/%b/%b want 0000/1/0", s, co, ov);
        end
        pop();
    endtask

    task automatic test_busy_window();
        logic [31:0] s; logic co, ov; int lat; bit rb;
        sel = 1;
        do_add(32'h1234, 32'h4321, 1'b1, s, co, ov, lat, rb);
        total++;
        if (rb !== 1'b0) begin bad++; $display("FAIL busy_in_ready got ready-while-busy=%b want 0", rb); end
        total++;
        if ({s, co, ov} !== {32'h5556, 1'b0, 1'b0}) begin
            bad++; $display("FAIL busy_result got %h/%b/%b want 5556/0/0", s, co, ov);
        end
        pop();
        total++;
        if ({ir_m, vld_m, sum_m} !== {1'b1, 1'b0, 32'h5556}) begin
            bad++; $display("FAIL busy_after_pop got rdy=%b vld=%b sum=%h want 1/0/5556", ir_m, vld_m, sum_m);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] s; logic co, ov; int lat; bit rb;
        sel = 1;
        do_add(32'h7FFF, 32'h0001, 1'b0, s, co, ov, lat, rb);
        total++;
        if ({s, co, ov} !== {32'h8000, 1'b0, 1'b1}) begin
            bad++; $display("FAIL ovf_pos got %h/%b/%b want 8000/0/1", s, co, ov);
        end
        pop();
        do_add(32'h8000, 32'h8000, 1'b0, s, co, ov, lat, rb);
        total++;
        if ({s, co, ov} !== {32'h0000, 1'b1, 1'b1}) begin
            bad++; $display("FAIL ovf_neg got %h/%b/%b want 0000/1/1", s, co, ov);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        int n;
        bit rb;
        sel = 1;
        a_d = 32'h00F0; b_d = 32'h0F0F; cin_d = 1'b0; iv_d = 1'b1;
        @(posedge clk); #1;
        a_d = 32'h0002; b_d = 32'h0003;
        n = 0; rb = 0;
        while (!vld_m && n < 64) begin
            if (ir_m) rb = 1;
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== 4 || rb) begin bad++; $display("FAIL b2b_first got lat=%0d ready_seen=%b want 4/0", n, rb); end
        total++;
        if ({sum_m, co_m, ovf_m} !== {32'h0FFF, 1'b0, 1'b0}) begin
            bad++; $display("FAIL b2b_first_result got %h/%b/%b want 0FFF/0/0", sum_m, co_m, ovf_m);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({vld_m, ir_m, sum_m, co_m, ovf_m} !== {1'b1, 1'b0, 32'h0FFF, 1'b0, 1'b0}) begin
                bad++; $display("FAIL b2b_hold%0d got vld=%b rdy=%b %h/%b/%b want 1/0/0FFF/0/0", i, vld_m, ir_m, sum_m, co_m, ovf_m);
            end
        end
        ordy_d = 1'b1;
        @(posedge clk); #1;
        ordy_d = 1'b0;
        total++;
        if ({ir_m, busy_m, vld_m} !== 3'b100) begin
            bad++; $display("FAIL b2b_pop_edge got rdy/busy/vld=%b want 100", {ir_m, busy_m, vld_m});
        end
        @(posedge clk); #1;
        iv_d = 1'b0;
        total++;
        if ({ir_m, busy_m} !== 2'b01) begin
            bad++; $display("FAIL b2b_second_accept got rdy/busy=%b want 01", {ir_m, busy_m});
        end
        n = 0;
        while (!vld_m && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== 4 || {sum_m, co_m, ovf_m} !== {32'h0005, 1'b0, 1'b0}) begin
            bad++; $display("FAIL b2b_second got lat=%0d %h/%b/%b want 4/0005/0/0", n, sum_m, co_m, ovf_m);
        end
        pop();
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] s; logic co, ov; int lat; bit rb;
        sel = 1;
        a_d = 32'hAAAA; b_d = 32'h5555; cin_d = 1'b0; iv_d = 1'b1;
        @(posedge clk); #1;
        iv_d = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if ({sum_m, co_m, vld_m, ir_m, busy_m} !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL midrun_reset got sum=%h cout=%b vld=%b rdy=%b busy=%b want 0/0/0/1/0", sum_m, co_m, vld_m, ir_m, busy_m);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_add(32'hAAAA, 32'h5555, 1'b1, s, co, ov, lat, rb);
        total++;
        if (lat !== 4 || {s, co, ov} !== {32'h0000, 1'b1, 1'b0}) begin
            bad++; $display("FAIL midrun_after got lat=%0d %h/%b/%b want 4/0000/1/0", lat, s, co, ov);
        end
        pop();
        do_add(32'hAAAA, 32'h5555, 1'b0, s, co, ov, lat, rb);
        total++;
        if ({s, co, ov} !== {32'hFFFF, 1'b0, 1'b0}) begin
            bad++; $display("FAIL midrun_after2 got %h/%b/%b want FFFF/0/0", s, co, ov);
        end
        pop();
    endtask

    task automatic test_width4();
        logic [31:0] s; logic co, ov; int lat; bit rb;
        sel = 0;
        do_add(32'hF, 32'h1, 1'b1, s, co, ov, lat, rb);
        total++;
        if (lat !== 1 || {s, co, ov} !== {32'h1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL w4_carry got lat=%0d %h/%b/%b want 1/1/1/0", lat, s, co, ov);
        end
        pop();
        do_add(32'h7, 32'h1, 1'b0, s, co, ov, lat, rb);
        total++;
        if ({s, co, ov} !== {32'h8, 1'b0, 1'b1}) begin
            bad++; $display("FAIL w4_ovf got %h/%b/%b want 8/0/1", s, co, ov);
        end
        pop();
    endtask

    task automatic test_random(input int which, input int w, input int n);
        logic [31:0] a, b, s, es; logic c, co, ov, eco, eov, cm; int lat; bit rb;
        logic [63:0] mask, m1, full;
        sel = which;
        mask = (64'd1 << w) - 64'd1;
        m1 = mask >> 1;
        for (int i = 0; i < n; i++) begin
            a = 32'($urandom & mask);
            b = 32'($urandom & mask);
            c = 1'($urandom_range(0, 1));
            full = 64'(a) + 64'(b) + 64'(c);
            es = 32'(full & mask);
            eco = full[w];
            cm = 1'(((64'(a) & m1) + (64'(b) & m1) + 64'(c)) >> (w - 1));
            eov = cm ^ eco;
            do_add(a, b, c, s, co, ov, lat, rb);
            total++;
            if (lat !== w / 4 || {s, co, ov} !== {es, eco, eov}) begin
                bad++; $display("FAIL rand_w%0d a=%h b=%h cin=%b got lat=%0d %h/%b/%b want %0d/%h/%b/%b", w, a, b, c, lat, s, co, ov, w / 4, es, eco, eov);
            end
            pop();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_window();
        test_overflow();
        test_back_to_back();
        test_reset_mid_run();
        test_width4();
        test_random(1, 16, 2000);
        test_random(2, 32, 2000);
        test_random(0, 4, 300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
